// File: rtl/alu_result_stage_pkg.sv
// Shared constants for the ALU result stage: datapath defaults, XZR index, NZCV bit layout.
package alu_result_stage_pkg;

   localparam int WIDTH_DEF = 64;
   localparam int RW_DEF    = 5;
   localparam int CNTW_DEF  = 16;

   // Register 31 reads as zero; writes to it are discarded.
   localparam int XZR_IDX = 31;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                             input logic c, input logic v);
      logic [3:0] f;
      f         = 4'b0000;
      f[FLAG_N] = n;
      f[FLAG_Z] = z;
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      return f;
   endfunction

endpackage

// File: rtl/alu_result_stage_zero_detect.sv
// Zero detector: NOR reduction as a 4-level tree of 4-input gates (up to 256 inputs).
// Purely combinational; one instance feeds out_zero, flag Z and the flag bypass.
module zero_detect #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] dat,
   output logic             zero
);

   localparam int LEAVES = 256;

   logic [LEAVES-1:0] pad;
   logic [63:0]       lvl1;
   logic [15:0]       lvl2;
   logic [3:0]        lvl3;

   // Unused upper leaves are tied low so they never mask a set bit.
   assign pad = LEAVES'(dat);

   for (genvar g = 0; g < 64; g++) begin : g_lvl1
      assign lvl1[g] = |pad[4*g +: 4];
   end

   for (genvar g = 0; g < 16; g++) begin : g_lvl2
      assign lvl2[g] = |lvl1[4*g +: 4];
   end

   for (genvar g = 0; g < 4; g++) begin : g_lvl3
      assign lvl3[g] = |lvl2[4*g +: 4];
   end

   assign zero = ~|lvl3;

endmodule

// File: rtl/alu_result_stage.sv
// EX/MEM output register behind the ALU: captures result/destination, keeps NZCV,
// bypasses next-cycle flags to branch logic, and counts bubbles (flush > stall > capture).
module alu_result_stage
   import alu_result_stage_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int RW    = RW_DEF,
   parameter int CNTW  = CNTW_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_result,
   input  logic             in_carry,
   input  logic             in_overflow,
   input  logic             in_set_flags,
   input  logic [RW-1:0]    in_rd,
   input  logic             in_reg_write,
   input  logic             stall,
   input  logic             flush,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_result,
   output logic [RW-1:0]    out_rd,
   output logic             out_reg_write,
   output logic             out_zero,
   output logic [3:0]       flags_q,
   output logic [3:0]       flags_fwd,
   output logic [CNTW-1:0]  bubble_cnt
);

   logic             valid_q,      valid_d;
   logic [WIDTH-1:0] result_q,     result_d;
   logic [RW-1:0]    rd_q,         rd_d;
   logic             reg_write_q,  reg_write_d;
   logic             zero_q,       zero_d;
   logic [3:0]       flags_d;
   logic [CNTW-1:0]  bubble_cnt_q, bubble_cnt_d;

   logic             res_zero;
   logic             capture;
   logic             load_bubble;
   logic             flag_upd;
   logic [3:0]       new_flags;

   zero_detect #(
      .WIDTH (WIDTH)
   ) u_zero_detect (
      .dat  (in_result),
      .zero (res_zero)
   );

   always_comb begin
      capture     = ~flush & ~stall;
      load_bubble = flush | (capture & ~in_valid);
      flag_upd    = capture & in_valid & in_set_flags;
      new_flags   = pack_flags(in_result[WIDTH-1], res_zero, in_carry, in_overflow);

      valid_d     = valid_q;
      result_d    = result_q;
      rd_d        = rd_q;
      reg_write_d = reg_write_q;
      zero_d      = zero_q;

      if (flush) begin
         valid_d     = 1'b0;
         result_d    = '0;
         rd_d        = '0;
         reg_write_d = 1'b0;
         zero_d      = 1'b0;
      end else if (capture) begin
         valid_d     = in_valid;
         result_d    = in_result;
         rd_d        = in_rd;
         reg_write_d = in_valid & in_reg_write & (in_rd != RW'(XZR_IDX));
         zero_d      = res_zero;
      end

      flags_d = flag_upd ? new_flags : flags_q;

      // Saturate rather than wrap so a long debug run never reads as "few bubbles".
      bubble_cnt_d = bubble_cnt_q;
      if (load_bubble && (bubble_cnt_q != {CNTW{1'b1}})) begin
         bubble_cnt_d = bubble_cnt_q + CNTW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q      <= 1'b0;
         result_q     <= '0;
         rd_q         <= '0;
         reg_write_q  <= 1'b0;
         zero_q       <= 1'b0;
         flags_q      <= 4'b0000;
         bubble_cnt_q <= '0;
      end else begin
         valid_q      <= valid_d;
         result_q     <= result_d;
         rd_q         <= rd_d;
         reg_write_q  <= reg_write_d;
         zero_q       <= zero_d;
         flags_q      <= flags_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign out_valid     = valid_q;
   assign out_result    = result_q;
   assign out_rd        = rd_q;
   assign out_reg_write = reg_write_q;
   assign out_zero      = zero_q;
   assign flags_fwd     = flags_d;
   assign bubble_cnt    = bubble_cnt_q;

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Execute-stage output register that sits directly downstream of the 64-bit ALU (bitwise AND/OR/XOR units, adder, result mux) and feeds the EX/MEM boundary of the pipelined ARM CPU. It captures the ALU result and destination info, derives N/Z from the result, and maintains the architectural NZCV flag register for flag-setting instructions (ADDS/SUBS/ANDS). It supplies a same-cycle flag bypass for B.cond, and provides stall/flush control plus a saturating bubble counter for performance debug.

## Interface
- WIDTH, 64, datapath width
- RW, 5, register-address width
- CNTW, 16, bubble-counter width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  ALU output holds a real instruction
- in_result  in  WIDTH  ALU result
- in_carry  in  1  adder carry-out
- in_overflow  in  1  adder signed overflow
- in_set_flags  in  1  instruction updates NZCV
- in_rd  in  RW  destination register
- in_reg_write  in  1  instruction writes rd
- stall  in  1  hold stage contents
- flush  in  1  kill the instruction being captured
- out_valid  out  1  registered valid
- out_result  out  WIDTH  registered result
- out_rd  out  RW  registered destination
- out_reg_write  out  1  registered write enable (never 1 for rd = 31)
- out_zero  out  1  registered (in_result == 0), for CBZ/CBNZ
- flags_q  out  4  architectural {N,Z,C,V}
- flags_fwd  out  4  bypassed flags for the instruction currently in decode/branch
- bubble_cnt  out  CNTW  saturating count of bubbles loaded

## Operation
- Reset (asynchronous, immediate): out_valid 0, out_result 0, out_rd 0, out_reg_write 0, out_zero 0, flags_q 4'b0000, bubble_cnt 0.
- Per rising edge, priority flush > stall > capture:
  - flush=1: out_valid 0, out_reg_write 0, out_zero 0, out_result 0, out_rd 0. Flags not updated. Counts as a bubble.
  - stall=1 (flush=0): every register holds, including flags_q and bubble_cnt.
  - else capture: out_valid←in_valid; out_result←in_result; out_rd←in_rd; out_zero←(in_result==0); out_reg_write←in_valid & in_reg_write & (in_rd≠31). If in_valid=0, the stage loads a bubble (counted).
- Flag update on capture when in_valid & in_set_flags: N←in_result[WIDTH-1], Z←(in_result==0), C←in_carry, V←in_overflow. Otherwise flags_q holds.
- flags_fwd (combinational): equals the value flags_q would take at the next edge, i.e. new {N,Z,C,V} when in_valid & in_set_flags & !stall & !flush, else flags_q.
- bubble_cnt: +1 on each edge that loads a bubble; saturates at 2^CNTW−1, never wraps.
- in_carry/in_overflow are ignored unless the flag update fires.

## Timing
- Result latency: 1 cycle, in_* at edge k → out_* valid after edge k.
- flags_fwd: zero-cycle bypass, combinational through the zero detector; stable before the clock edge, given inputs settle by the ALU's worst-case delay.
- Simultaneous stall & flush: flush wins; the stage empties.
- Reset asserted mid-stall or mid-flush: all state clears immediately. The first capture occurs on the first edge after reset deasserts.
- Consecutive flag setters: each one updates flags_q on its own capture edge; there is no merging.

## Structure
- Shared package: WIDTH/RW defaults, XZR index constant (31), flag bit positions (N=3, Z=2, C=1, V=0).
- Sub-module zero_detect: a WIDTH-bit NOR reduction built from a 4-level tree of 4-input gates, 50 ps primitive delay. It is instantiated once and shared by out_zero, flag Z, and flags_fwd.
- Storage uses D flip-flops with asynchronous reset. Hold and flush behaviour is implemented as a 2:1 or 3:1 mux in front of each flop.

## Test plan
- Reset then idle (in_valid 0) for 5 cycles → all outputs 0, bubble_cnt 5 after deassert; reset pulse mid-run → bubble_cnt 0 immediately.
- ANDS with in_result 64'h8000_0000_0000_0000, set_flags=1, rd=3 → next cycle out_result matches, out_reg_write 1, flags_q 4'b1000, out_zero 0; flags_fwd 4'b1000 in the capture cycle before the edge.
- SUBS with result 0, carry 1, overflow 0 → flags_q 4'b0110, out_zero 1; following ADD without set_flags → flags_q unchanged.
- in_rd=31, reg_write=1, result 64'h5 → out_reg_write 0, out_result 64'h5, out_valid 1.
- stall=1 for 3 cycles with changing inputs → outputs and flags frozen; stall=1 & flush=1 together → out_valid 0, flags unchanged, bubble_cnt +1.
- CNTW forced to 2, 6 bubbles loaded → bubble_cnt saturates at 3.
